matrix_normalizer: RTL and testbench

- Min-max normalizes a SIZE x SIZE matrix of signed 16-bit values into unsigned 8-bit values spanning 0..255.
- Sits between the systolic-array accumulator output and the 8-bit storage/display path of the NPU.
- Sequential: one scan pass finds the min and max, then one pass computes the outputs. Both passes process one element per cycle.

---
 rtl/matrix_normalizer.sv | 110 +++++++++++
 tb/tb_matrix_normalizer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_normalizer.sv
// rtl/matrix_normalizer.sv - two-pass min/max scan then per-element min-max scaling to unsigned
module matrix_normalizer #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 8,
    parameter int SIZE      = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [WIDTH_IN-1:0]  matrix_in  [0:SIZE-1][0:SIZE-1],
    output logic                        done,
    output logic        [WIDTH_OUT-1:0] matrix_out [0:SIZE-1][0:SIZE-1]
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PW = WIDTH_IN + 1 + WIDTH_OUT;
    localparam logic [PW-1:0] FULL_SCALE = PW'((1 << WIDTH_OUT) - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, NORM, FINISH} state_t;

    state_t                      state;
    logic signed [WIDTH_IN-1:0]  copy [0:SIZE-1][0:SIZE-1];
    logic signed [WIDTH_IN-1:0]  min_v;
    logic signed [WIDTH_IN-1:0]  max_v;
    logic        [IW-1:0]        row;
    logic        [IW-1:0]        col;

    logic signed [WIDTH_IN-1:0]  cur;
    logic        [WIDTH_IN:0]    diff;
    logic        [WIDTH_IN:0]    span;
    logic        [WIDTH_OUT-1:0] q;
    logic                        last_elem;

    assign last_elem = (row == LAST_IDX) && (col == LAST_IDX);

    // Scaled value of the current element; a zero span means a constant matrix, which maps to 0
    always_comb begin
        cur  = copy[row][col];
        diff = {cur[WIDTH_IN-1], cur} - {min_v[WIDTH_IN-1], min_v};
        span = {max_v[WIDTH_IN-1], max_v} - {min_v[WIDTH_IN-1], min_v};
        q    = '0;
        if (span != '0) begin
            q = WIDTH_OUT'(({{WIDTH_OUT{1'b0}}, diff} * FULL_SCALE) / {{WIDTH_OUT{1'b0}}, span});
        end
    end

    // Control FSM: capture input, scan for extremes, write scaled outputs, then hold the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            min_v <= '0;
            max_v <= '0;
            row   <= '0;
            col   <= '0;
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    copy[r][c]       <= '0;
                    matrix_out[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        copy  <= matrix_in;
                        done  <= 1'b0;
                        row   <= '0;
                        col   <= '0;
                        min_v <= matrix_in[0][0];
                        max_v <= matrix_in[0][0];
                        state <= SCAN;
                    end else if (state == FINISH) begin
                        done <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cur < min_v) min_v <= cur;
                    if (cur > max_v) max_v <= cur;
                    if (last_elem) begin
                        row   <= '0;
                        col   <= '0;
                        state <= NORM;
                    end else if (col == LAST_IDX) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                NORM: begin
                    matrix_out[row][col] <= q;
                    if (last_elem) begin
                        row   <= '0;
                        col   <= '0;
                        state <= FINISH;
                    end else if (col == LAST_IDX) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_normalizer.sv
// tb/tb_matrix_normalizer.sv - self-checking bench for matrix_normalizer
module tb_matrix_normalizer;

    localparam int N = 10;
    localparam int LAT = 2 * N * N + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] mat  [0:N-1][0:N-1];
    logic               done;
    logic        [7:0]  mout [0:N-1][0:N-1];

    int exp_m [0:N-1][0:N-1];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int r;
        int c;
        int val;
        int expv;
    } vec_t;
    vec_t tbl [22];

    matrix_normalizer #(.WIDTH_IN(16), .WIDTH_OUT(8), .SIZE(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .matrix_in(mat), .done(done), .matrix_out(mout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic cmp_all(input string name);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk($sformatf("%s[%0d][%0d]", name, r, c), int'(mout[r][c]), exp_m[r][c]);
    endtask

    // Reference: plain min-max scaling over the whole matrix
    task automatic model();
        int mn, mx, x;
        mn = int'(mat[0][0]);
        mx = mn;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                x = int'(mat[r][c]);
                if (x < mn) mn = x;
                if (x > mx) mx = x;
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_m[r][c] = (mx == mn) ? 0 : ((int'(mat[r][c]) - mn) * 255) / (mx - mn);
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 16'($urandom_range(0, hi - lo) + lo);
    endtask

    task automatic scramble();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 16'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int glitch_at, output int n);
        n = 0;
        while (!done && n < 400) begin
            start = (n == glitch_at);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic run(input string name, input int glitch_at);
        int n;
        model();
        pulse_start();
        scramble();
        wait_done(glitch_at, n);
        chk({name, "_latency"}, n, LAT);
        cmp_all(name);
    endtask

    initial begin
        int n;
        int nz;
        tbl[0]  = '{0, 0, 1500, 136};  tbl[1]  = '{0, 1, 1890, 162};
        tbl[2]  = '{0, 2, 2320, 190};  tbl[3]  = '{0, 3, 2790, 221};
        tbl[4]  = '{0, 4, 3300, 255};  tbl[5]  = '{0, 5, 3150, 245};
        tbl[6]  = '{0, 6, 2960, 232};  tbl[7]  = '{0, 7, 2730, 217};
        tbl[8]  = '{0, 8, 2460, 199};  tbl[9]  = '{0, 9, 2150, 179};
        tbl[10] = '{9, 0, -285, 19};   tbl[11] = '{9, 1, -350, 14};
        tbl[12] = '{9, 2, -420, 10};   tbl[13] = '{9, 3, -495, 5};
        tbl[14] = '{9, 4, -575, 0};    tbl[15] = '{9, 5, -540, 2};
        tbl[16] = '{9, 6, -500, 4};    tbl[17] = '{9, 7, -455, 7};
        tbl[18] = '{9, 8, -405, 11};   tbl[19] = '{9, 9, -350, 14};
        tbl[20] = '{3, 3, -6, 37};     tbl[21] = '{4, 4, 750, 87};

        // Reset state
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat[r][c] = '0;
                exp_m[r][c] = 0;
            end
        repeat (3) @(negedge clk);
        chk("reset_done", int'(done), 0);
        cmp_all("reset_out");
        reset = 1'b0;
        @(negedge clk);

        // Run 1: reference matrix, table of spot checks
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 16'(1000);
        foreach (tbl[i]) mat[tbl[i].r][tbl[i].c] = 16'(tbl[i].val);
        model();
        pulse_start();
        scramble();
        wait_done(-1, n);
        chk("run1_latency", n, LAT);
        foreach (tbl[i])
            chk($sformatf("run1_tbl%0d", i), int'(mout[tbl[i].r][tbl[i].c]), tbl[i].expv);
        cmp_all("run1");

        // Result holds for well over 100 ns
        repeat (15) @(posedge clk);
        #1;
        chk("hold_done", int'(done), 1);
        cmp_all("hold");

        // Full-range extremes
        fill_random(-1000, 1000);
        mat[2][5] = -16'sd32768;
        mat[7][1] = 16'sd32767;
        mat[5][5] = 16'sd0;
        model();
        pulse_start();
        wait_done(-1, n);
        chk("ext_latency", n, LAT);
        chk("ext_min", int'(mout[2][5]), 0);
        chk("ext_max", int'(mout[7][1]), 255);
        chk("ext_zero", int'(mout[5][5]), 127);
        cmp_all("ext");

        // Constant matrix
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 16'sd1234;
        run("const", -1);

        // Start pulse during SCAN is ignored
        fill_random(-32768, 32767);
        run("busy", 50);

        // Asynchronous reset mid-NORM
        fill_random(-5000, 5000);
        pulse_start();
        repeat (150) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_done", int'(done), 0);
        nz = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (mout[r][c] != 8'd0) nz++;
        chk("midrst_nonzero", nz, 0);
        @(negedge clk);
        reset = 1'b0;
        fill_random(-5000, 5000);
        run("after_rst", -1);

        // Back-to-back from FINISH with a narrower range
        fill_random(100, 200);
        model();
        pulse_start();
        chk("b2b_done_drop", int'(done), 0);
        wait_done(-1, n);
        chk("b2b_latency", n, LAT);
        cmp_all("b2b");

        // Random runs
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0: fill_random(-32768, 32767);
                1: fill_random(-3, 3);
                default: fill_random(20000, 20300);
            endcase
            run($sformatf("rnd%0d", k), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
